// File: rtl/seg7_monitor.sv
// seg7_monitor: loopback checker for an active-low seven-segment bus.
// Waits for each pattern to settle, decodes it to a digit, flags Fibonacci
// digits, checks that digits advance by one modulo 16, and counts errors.
module seg7_monitor #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_seg,
    input  logic       i_display_on,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_fib,
    output logic       o_invalid,
    output logic       o_seq_err,
    output logic [7:0] o_err_count,
    output logic       o_locked
);

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEG_W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEG_W-1:0]     acc_q, acc_d;
    logic                 has_acc_q, has_acc_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic                 valid_q, valid_d;
    logic                 fib_q, fib_d;
    logic                 invalid_q, invalid_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 locked_q, locked_d;
    logic [DIGIT_W:0]     cand_dec;

    // Pattern decode: bit 4 = legal, bits 3:0 = digit.
    function automatic logic [DIGIT_W:0] decode(input logic [SEG_W-1:0] p);
        logic [DIGIT_W:0] r;
        case (p)
            8'hC0:   r = 5'h10;
            8'hF9:   r = 5'h11;
            8'hA4:   r = 5'h12;
            8'hB0:   r = 5'h13;
            8'h99:   r = 5'h14;
            8'h92:   r = 5'h15;
            8'h82:   r = 5'h16;
            8'hF8:   r = 5'h17;
            8'h80:   r = 5'h18;
            8'h90:   r = 5'h19;
            8'h88:   r = 5'h1A;
            8'h83:   r = 5'h1B;
            8'hC6:   r = 5'h1C;
            8'hA1:   r = 5'h1D;
            8'h86:   r = 5'h1E;
            8'h8E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Fibonacci membership for a 4-bit digit.
    function automatic logic is_fib(input logic [DIGIT_W-1:0] d);
        logic r;
        case (d)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    assign cand_dec = decode(cand_q);

    // Next-state and output logic: settle tracking, acceptance, error accounting.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        has_acc_d = has_acc_q;
        digit_d   = digit_q;
        valid_d   = 1'b0;
        fib_d     = fib_q;
        invalid_d = invalid_q;
        seq_err_d = 1'b0;
        err_d     = err_q;
        locked_d  = locked_q;

        if (!i_display_on) begin
            state_d   = IDLE;
            cand_d    = '0;
            cnt_d     = '0;
            has_acc_d = 1'b0;
            locked_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SETTLE;
                    cand_d    = i_seg;
                    cnt_d     = CNT_W'(1);
                    has_acc_d = 1'b0;
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
                        state_d   = LOCKED;
                        acc_d     = cand_q;
                        has_acc_d = 1'b1;
                        cnt_d     = '0;
                        if (cand_dec[DIGIT_W]) begin
                            digit_d   = cand_dec[DIGIT_W-1:0];
                            fib_d     = is_fib(cand_dec[DIGIT_W-1:0]);
                            invalid_d = 1'b0;
                            valid_d   = 1'b1;
                            locked_d  = 1'b1;
                            if (locked_q &&
                                (cand_dec[DIGIT_W-1:0] != DIGIT_W'(digit_q + 4'd1))) begin
                                seq_err_d = 1'b1;
                                err_d = (err_q == '1) ? err_q : ERR_W'(err_q + 8'd1);
                            end
                        end else begin
                            invalid_d = 1'b1;
                            err_d = (err_q == '1) ? err_q : ERR_W'(err_q + 8'd1);
                        end
                    end else if (has_acc_q && (i_seg == acc_q)) begin
                        // Short excursion ended back on the accepted pattern.
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else if (i_seg == cand_q) begin
                        cnt_d = CNT_W'(cnt_q + 8'd1);
                    end else begin
                        cand_d = i_seg;
                        cnt_d  = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (i_seg != acc_q) begin
                        state_d = SETTLE;
                        cand_d  = i_seg;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cand_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            has_acc_q <= 1'b0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            fib_q     <= 1'b0;
            invalid_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            has_acc_q <= has_acc_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            fib_q     <= fib_d;
            invalid_q <= invalid_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign o_digit     = digit_q;
    assign o_valid     = valid_q;
    assign o_fib       = fib_q;
    assign o_invalid   = invalid_q;
    assign o_seq_err   = seq_err_q;
    assign o_err_count = err_q;
    assign o_locked    = locked_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: directed plus randomized stimulus for seg7_monitor,
// checked every cycle against a behavioural model of the monitor.
module tb_seg7_monitor;

    localparam int unsigned N = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg;
    logic       on;
    logic [3:0] o_digit;
    logic       o_valid;
    logic       o_fib;
    logic       o_invalid;
    logic       o_seq_err;
    logic [7:0] o_err_count;
    logic       o_locked;

    int tests = 0;
    int fails = 0;

    seg7_monitor #(.STABLE_CYCLES(N)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_seg        (seg),
        .i_display_on (on),
        .o_digit      (o_digit),
        .o_valid      (o_valid),
        .o_fib        (o_fib),
        .o_invalid    (o_invalid),
        .o_seq_err    (o_seq_err),
        .o_err_count  (o_err_count),
        .o_locked     (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic int dec(input logic [7:0] p);
        for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run of identical samples N long is accepted on the
    // following edge; samples equal to the settled pattern are simply ignored.
    int         m_digit, m_err, m_run_len;
    bit         m_valid, m_fib, m_invalid, m_seq, m_locked;
    bit         m_has_settled, m_pending;
    logic [7:0] m_settled, m_run_pat, m_pend_pat;

    task automatic m_bump();
        if (m_err < 255) m_err++;
    endtask

    task automatic m_accept(input logic [7:0] p);
        int d;
        d = dec(p);
        if (d >= 0) begin
            if (m_locked && d != (m_digit + 1) % 16) begin
                m_seq = 1;
                m_bump();
            end
            m_digit   = d;
            m_fib     = (d inside {0, 1, 2, 3, 5, 8, 13});
            m_invalid = 0;
            m_valid   = 1;
            m_locked  = 1;
        end else begin
            m_invalid = 1;
            m_bump();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digit = 0; m_err = 0; m_run_len = 0;
            m_valid = 0; m_fib = 0; m_invalid = 0; m_seq = 0; m_locked = 0;
            m_has_settled = 0; m_pending = 0;
            m_settled = '0; m_run_pat = '0; m_pend_pat = '0;
        end else begin
            m_valid = 0;
            m_seq   = 0;
            if (!on) begin
                m_has_settled = 0;
                m_pending     = 0;
                m_run_len     = 0;
                m_locked      = 0;
            end else if (m_pending) begin
                m_accept(m_pend_pat);
                m_pending     = 0;
                m_has_settled = 1;
                m_settled     = m_pend_pat;
                m_run_len     = 0;
            end else if (m_has_settled && seg == m_settled) begin
                m_run_len = 0;
            end else begin
                if (m_run_len > 0 && seg == m_run_pat) m_run_len++;
                else begin
                    m_run_pat = seg;
                    m_run_len = 1;
                end
                if (m_run_len == N) begin
                    m_pending  = 1;
                    m_pend_pat = m_run_pat;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("outputs",
              {15'd0, o_digit, o_valid, o_fib, o_invalid, o_seq_err, o_err_count, o_locked},
              {15'd0, 4'(m_digit), m_valid, m_fib, m_invalid, m_seq, 8'(m_err), m_locked});
    end

    task automatic cyc(input logic [7:0] p, input logic en);
        seg = p;
        on  = en;
        @(posedge clk);
        #1;
    endtask

    // Hold a new pattern; the acceptance pulse is visible after the 5th edge.
    task automatic accept_chk(input logic [7:0] p, input int d, input bit f, input bit sq);
        for (int i = 0; i < N + 1; i++) cyc(p, 1'b1);
        check("valid_pulse", 32'(o_valid), 32'd1);
        check("digit", 32'(o_digit), 32'(d));
        check("fib", 32'(o_fib), 32'(f));
        check("seq_err", 32'(o_seq_err), 32'(sq));
        cyc(p, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        seg   = 8'hFF;
        on    = 1'b0;
        #12;
        check("reset_state",
              {o_digit, o_valid, o_fib, o_invalid, o_seq_err, o_err_count, o_locked}, 32'd0);
        #10 rst_n = 1'b1;

        // First digit: pulse exactly after edge 5, never a sequence error.
        for (int i = 0; i < N; i++) cyc(8'hC0, 1'b1);
        check("no_early_valid", 32'(o_valid), 32'd0);
        cyc(8'hC0, 1'b1);
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_digit", 32'(o_digit), 32'd0);
        check("first_fib", 32'(o_fib), 32'd1);
        check("first_locked", 32'(o_locked), 32'd1);
        check("first_seq", 32'(o_seq_err), 32'd0);
        cyc(8'hC0, 1'b1);

        accept_chk(8'hF9, 1, 1, 0);
        accept_chk(8'hA4, 2, 1, 0);
        accept_chk(8'hB0, 3, 1, 0);
        accept_chk(8'h99, 4, 0, 0);
        accept_chk(8'h92, 5, 1, 0);
        check("err_after_count", 32'(o_err_count), 32'd0);

        // 5 -> F is a break, F -> 0 wraps cleanly, 0 -> 3 is a break.
        accept_chk(8'h8E, 15, 0, 1);
        accept_chk(8'hC0, 0, 1, 0);
        accept_chk(8'hB0, 3, 1, 1);
        check("err_after_breaks", 32'(o_err_count), 32'd2);

        // 3 -> 1 break, then a 3-sample glitch is ignored.
        accept_chk(8'hF9, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(8'h80, 1'b1);
        for (int i = 0; i < 6; i++) cyc(8'hF9, 1'b1);
        check("glitch_digit", 32'(o_digit), 32'd1);
        check("glitch_err", 32'(o_err_count), 32'd3);

        // dp lit: invalid acceptance, digit unchanged.
        for (int i = 0; i < N + 1; i++) cyc(8'h7F, 1'b1);
        check("inv_flag", 32'(o_invalid), 32'd1);
        check("inv_valid", 32'(o_valid), 32'd0);
        check("inv_err", 32'(o_err_count), 32'd4);
        check("inv_digit", 32'(o_digit), 32'd1);

        // Display dropped mid-settle, then re-lock with no sequence error.
        cyc(8'hC0, 1'b1);
        cyc(8'hC0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'hC0, 1'b0);
        check("off_locked", 32'(o_locked), 32'd0);
        check("off_valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < N; i++) cyc(8'hA4, 1'b1);
        check("relock_early", 32'(o_valid), 32'd0);
        cyc(8'hA4, 1'b1);
        check("relock_valid", 32'(o_valid), 32'd1);
        check("relock_seq", 32'(o_seq_err), 32'd0);
        check("relock_digit", 32'(o_digit), 32'd2);
        check("relock_err", 32'(o_err_count), 32'd4);
        cyc(8'hA4, 1'b1);

        // Randomized traffic: mostly counting, with jumps, junk and enable drops.
        begin
            int cur;
            cur = 2;
            for (int it = 0; it < 400; it++) begin
                int r, len;
                logic [7:0] p;
                bit en;
                r   = $urandom_range(0, 99);
                len = $urandom_range(1, 7);
                en  = 1'b1;
                if (r < 65) begin
                    cur = (cur + 1) % 16;
                    p = codes[cur];
                end else if (r < 80) begin
                    cur = $urandom_range(0, 15);
                    p = codes[cur];
                end else if (r < 93) begin
                    p = 8'($urandom);
                end else begin
                    p  = codes[cur];
                    en = 1'b0;
                end
                for (int k = 0; k < len; k++) cyc(p, en);
            end
        end

        // Saturation: alternate two invalid patterns long enough to accept each.
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < N + 1; k++) cyc((i % 2 == 0) ? 8'h7F : 8'hFF, 1'b1);
        end
        check("err_saturated", 32'(o_err_count), 32'd255);
        check("sat_invalid", 32'(o_invalid), 32'd1);

        // Asynchronous reset between edges clears outputs at once.
        #3 rst_n = 1'b0;
        #1;
        check("async_reset",
              {o_digit, o_valid, o_fib, o_invalid, o_seq_err, o_err_count, o_locked}, 32'd0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(8'hF9, 1'b1);
        check("post_reset_digit", 32'(o_digit), 32'd1);
        check("post_reset_err", 32'(o_err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
